// File: rtl/cpu_pkg.sv
// Shared CPU definitions used by the fetch front end and its FIFO.
//   NOP_INSTR     : word the core executes as a no-op when nothing is valid
//   INSTR_W       : instruction width
//   PC_STEP       : byte increment between sequential fetches
//   fetch_entry_t : one buffered fetch, {pc, instr}
package cpu_pkg;
    localparam int          INSTR_W   = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP   = 32'd4;

    typedef struct packed {
        logic [31:0]        pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with occupancy count and flush.
//   clock : rising-edge clock
//   flush : empties the FIFO; wins over push and pop
//   push  : write wdata at the tail (may coincide with pop when full)
//   pop   : advance the head (caller guarantees count != 0)
//   wdata : data to write
//   head  : data at the head; undefined when count == 0
//   count : number of stored entries, 0..DEPTH
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64
) (
    input  logic                         clock,
    input  logic                         flush,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;

    // Storage has no reset; only the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (push && !flush) mem[wr_ptr] <= wdata;
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    assign head = mem[rd_ptr];
endmodule

// File: rtl/fetch_queue.sv
// Instruction-fetch front end feeding the pipelined core.
// Generates sequential word-aligned fetch addresses, issues them to a
// 1-cycle-latency instruction memory and buffers returned words with their
// PCs. A redirect flushes the buffer and drops any in-flight response.
//   clock       : rising-edge clock
//   start       : synchronous active-low reset
//   imem_req    : fetch request this cycle
//   imem_addr   : word-aligned request address
//   imem_valid  : response valid, one cycle after imem_req
//   imem_data   : returned instruction word
//   redirect    : branch/jump taken; flush and refetch from redirect_pc
//   redirect_pc : new target, bits [1:0] ignored
//   instr_ready : core accepts instr_out this cycle
//   instr_valid : instr_out/instr_pc hold a real instruction
//   instr_out   : head instruction, NOP when not valid
//   instr_pc    : head PC, 0 when not valid
module fetch_queue
    import cpu_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clock,
    input  logic               start,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_valid,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    input  logic               instr_ready,
    output logic               instr_valid,
    output logic [INSTR_W-1:0] instr_out,
    output logic [31:0]        instr_pc
);
    localparam int CW = $clog2(DEPTH+1);
    localparam int EW = $bits(fetch_entry_t);

    logic [31:0]   fetch_pc;
    logic [31:0]   inflight_pc;
    logic          inflight;
    logic [CW-1:0] count;
    logic [CW:0]   used;
    logic          has_credit;
    logic          push;
    logic          pop;
    logic          flush;
    fetch_entry_t  wr_entry;
    fetch_entry_t  head_entry;
    logic [EW-1:0] head_bits;

    // Credits: a slot is reserved for every outstanding request so that a
    // response can always be pushed without overflow.
    always_comb begin
        used       = {1'b0, count} + {{CW{1'b0}}, inflight};
        has_credit = used < (CW+1)'(DEPTH);
    end

    assign imem_req  = start && !redirect && has_credit;
    assign imem_addr = fetch_pc;

    // inflight gating drops a response to a request issued before a reset.
    assign push  = imem_valid && inflight && !redirect;
    assign pop   = instr_valid && instr_ready;
    assign flush = !start || redirect;

    always_ff @(posedge clock) begin
        if (!start) begin
            fetch_pc    <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= RESET_PC;
        end else begin
            inflight    <= imem_req;
            inflight_pc <= fetch_pc;
            if (redirect)
                fetch_pc <= {redirect_pc[31:2], 2'b00};
            else if (imem_req)
                fetch_pc <= fetch_pc + PC_STEP;
        end
    end

    always_comb begin
        wr_entry       = '0;
        wr_entry.pc    = inflight_pc;
        wr_entry.instr = imem_data;
    end

    sync_fifo #(.DEPTH(DEPTH), .WIDTH(EW)) u_fifo (
        .clock (clock),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .head  (head_bits),
        .count (count)
    );

    assign head_entry  = head_bits;
    assign instr_valid = (count != '0);
    assign instr_out   = instr_valid ? head_entry.instr : NOP_INSTR;
    assign instr_pc    = instr_valid ? head_entry.pc    : 32'h0;
endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: the stimulus loads the expected delivery
// stream (PC sequence, data = pc ^ A5A5_0000) and a negedge monitor pops and
// compares every accepted instruction. Directed checks cover reset, stall,
// redirect, collision, wrap and mid-operation reset.
module tb_fetch_queue;
    import cpu_pkg::*;

    logic        clock = 1'b0;
    logic        start = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_valid = 1'b0;
    logic [31:0] imem_data = 32'h0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_ready = 1'b1;
    logic        instr_valid;
    logic [31:0] instr_out;
    logic [31:0] instr_pc;

    int errors = 0;
    int checks = 0;
    fetch_entry_t sbq[$];
    fetch_entry_t mon_e;

    fetch_queue #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .clock       (clock),
        .start       (start),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_valid  (imem_valid),
        .imem_data   (imem_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instr_ready (instr_ready),
        .instr_valid (instr_valid),
        .instr_out   (instr_out),
        .instr_pc    (instr_pc)
    );

    always #5 clock = ~clock;

    // 1-cycle instruction memory: data = addr ^ A5A5_0000.
    always @(posedge clock) begin
        imem_valid <= imem_req;
        imem_data  <= imem_addr ^ 32'hA5A5_0000;
    end

    // Monitor: every instruction the core accepts must match the scoreboard head.
    always @(negedge clock) begin
        if (start && !redirect && instr_valid && instr_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL deliver: unexpected pc %08h, scoreboard empty", instr_pc);
            end else begin
                mon_e = sbq.pop_front();
                if (instr_pc !== mon_e.pc || instr_out !== mon_e.instr) begin
                    errors++;
                    $display("FAIL deliver: got pc %08h instr %08h, expected pc %08h instr %08h",
                             instr_pc, instr_out, mon_e.pc, mon_e.instr);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic load_exp(input logic [31:0] base, input int n);
        fetch_entry_t e;
        sbq.delete();
        for (int i = 0; i < n; i++) begin
            e.pc    = base + 32'(i * 4);
            e.instr = e.pc ^ 32'hA5A5_0000;
            sbq.push_back(e);
        end
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) step();
        settle();
        chk("rst_req",   32'(imem_req),    32'd0);
        chk("rst_addr",  imem_addr,        32'h0);
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_out",   instr_out,        32'h0);
        chk("rst_pc",    instr_pc,         32'h0);

        // Stream from reset
        load_exp(32'h0, 32);
        start = 1'b1;
        settle();
        chk("c0_req",  32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr,     32'h0);
        step(); settle();
        chk("c1_valid", 32'(instr_valid), 32'd0);
        chk("c1_addr",  imem_addr,        32'h4);
        step(); settle();
        chk("c2_valid", 32'(instr_valid), 32'd1);
        chk("c2_pc",    instr_pc,         32'h0);

        // Stall fill from cycle 3
        step(); instr_ready = 1'b0; settle();
        chk("c3_pc", instr_pc, 32'h4);
        repeat (3) step();
        settle();
        chk("full_count", 32'(dut.count), 32'd4);
        chk("full_req",   32'(imem_req),  32'd0);
        step(); settle();
        chk("full_req2",  32'(imem_req),  32'd0);
        chk("full_count2", 32'(dut.count), 32'd4);
        chk("full_pc",    instr_pc,       32'h4);
        step(); instr_ready = 1'b1; settle();
        chk("rel_req",  32'(imem_req), 32'd0);
        step(); settle();
        chk("rel_req2", 32'(imem_req), 32'd1);
        chk("rel_addr", imem_addr,     32'h14);
        repeat (6) step();

        // Redirect while holding 3 entries
        instr_ready = 1'b0;
        n = 0;
        while (dut.count != 3 && n < 8) begin
            step();
            n++;
        end
        settle();
        chk("pre_redir_count", 32'(dut.count), 32'd3);
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0040;
        load_exp(32'h40, 32);
        settle();
        chk("redir_req", 32'(imem_req), 32'd0);
        step(); redirect = 1'b0; instr_ready = 1'b1; settle();
        chk("r1_addr",  imem_addr,        32'h40);
        chk("r1_req",   32'(imem_req),    32'd1);
        chk("r1_valid", 32'(instr_valid), 32'd0);
        chk("r1_count", 32'(dut.count),   32'd0);
        step(); settle();
        chk("r2_valid", 32'(instr_valid), 32'd0);
        step(); settle();
        chk("r3_valid", 32'(instr_valid), 32'd1);
        chk("r3_pc",    instr_pc,         32'h40);
        repeat (5) step();

        // Redirect colliding with a response, unaligned target with wrap
        settle();
        chk("collide_pre", 32'(imem_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFE;
        load_exp(32'hFFFF_FFFC, 32);
        step(); redirect = 1'b0; settle();
        chk("col_count", 32'(dut.count), 32'd0);
        chk("col_addr",  imem_addr,      32'hFFFF_FFFC);
        chk("col_req",   32'(imem_req),  32'd1);
        step(); settle();
        chk("wrap_addr", imem_addr, 32'h0);
        step(); settle();
        chk("wrap_valid", 32'(instr_valid), 32'd1);
        chk("wrap_pc",    instr_pc,         32'hFFFF_FFFC);
        chk("wrap_instr", instr_out,        32'h5A5A_FFFC);
        repeat (5) step();

        // Mid-operation reset for one cycle
        start = 1'b0;
        settle();
        chk("mrst_req", 32'(imem_req), 32'd0);
        load_exp(32'h0, 32);
        step(); start = 1'b1; settle();
        chk("mrst_valid", 32'(instr_valid), 32'd0);
        chk("mrst_out",   instr_out,        32'h0);
        chk("mrst_count", 32'(dut.count),   32'd0);
        chk("mrst_addr",  imem_addr,        32'h0);
        chk("mrst_req2",  32'(imem_req),    32'd1);
        step(); settle();
        chk("mrst_valid1", 32'(instr_valid), 32'd0);
        step(); settle();
        chk("mrst_valid2", 32'(instr_valid), 32'd1);
        chk("mrst_pc",     instr_pc,         32'h0);
        repeat (6) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
